// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// requester indices and select width.
package mux_rr_arbiter_pkg;

    localparam int SEL_W = 2;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;
    localparam int REQ_C = 2;
    localparam int REQ_D = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    function automatic logic [3:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-facing bundle of the arbiter: requests and releases in,
// grant, mux select and status out.
interface mux_rr_arbiter_if;

    logic [3:0]                          req;
    logic [3:0]                          done;
    logic [3:0]                          grant;
    logic [mux_rr_arbiter_pkg::SEL_W-1:0] s;
    logic                                valid;
    logic                                timeout;

    modport master (
        output req, done,
        input  grant, s, valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, s, valid, timeout
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request scanning upward
// from the pointer, modulo 4.
module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest candidate back to the pointer so the closest one wins.
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        idx    = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared dual 4:1 mux select with settle and
// turnaround cycles. Optional grant timeout enabled by MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int SETTLE   = 1,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    arb_state_t       state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [2:0]       settle_q, settle_d;
    logic             natural_rel;
    logic             forced_rel;
    logic [SEL_W-1:0] winner;
    logic             any_req;
`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0]       hold_q, hold_d;
    logic             timeout_q, timeout_d;
`endif

    rr_pick4 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            s_q       <= SEL_W'(REQ_A);
            valid_q   <= 1'b0;
            ptr_q     <= SEL_W'(REQ_A);
            settle_q  <= 3'd0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            s_q       <= s_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            settle_q  <= settle_d;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // A natural release (Done or dropped Req of the owner) beats a forced one.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        s_d         = s_q;
        valid_d     = valid_q;
        ptr_d       = ptr_q;
        settle_d    = settle_q;
        natural_rel = bus.done[s_q] | ~bus.req[s_q];
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
        forced_rel  = (hold_q == 8'(HOLD_MAX - 1));
`else
        forced_rel  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d  = onehot4(winner);
                    s_d      = winner;
                    settle_d = 3'd0;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d   = 8'd0;
`endif
                    if (SETTLE == 0) begin
                        state_d = ST_OWN;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        valid_d = 1'b0;
                    end
                end
            end
            ST_SETTLE, ST_OWN: begin
`ifdef MUX_ARB_TIMEOUT_EN
                hold_d = hold_q + 8'd1;
`endif
                if (natural_rel || forced_rel) begin
                    state_d   = ST_RELEASE;
                    grant_d   = 4'b0000;
                    valid_d   = 1'b0;
                    ptr_d     = s_q + SEL_W'(1);
`ifdef MUX_ARB_TIMEOUT_EN
                    timeout_d = ~natural_rel;
`endif
                end else if (state_q == ST_SETTLE) begin
                    if (settle_q == 3'(SETTLE - 1)) begin
                        state_d = ST_OWN;
                        valid_d = 1'b1;
                    end else begin
                        settle_d = settle_q + 3'd1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.s     = s_q;
    assign bus.valid = valid_q;
`ifdef MUX_ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule
